// File: rtl/psram_pkg.sv
// psram_pkg: shared FSM states, slot counts and slot-length limits for the OPI PSRAM sequencer.
package psram_pkg;
    localparam int PSCR_W = 20;
    localparam int SLOT_W = 10;
    localparam int CMD_SLOTS = 2;
    localparam int ADDR_SLOTS = 4;
    localparam logic [PSCR_W-1:0] P_MIN = PSCR_W'(2);
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_WAIT, ST_DATA, ST_HOLD} state_e;
    function automatic logic [PSCR_W-1:0] eff_p(input logic [PSCR_W-1:0] v);
        return v < P_MIN ? P_MIN : v;
    endfunction
    // Address goes out most significant byte first.
    function automatic logic [7:0] addr_byte(input logic [31:0] a, input logic [1:0] i);
        return 8'(a >> (5'd24 - {i, 3'b000}));
    endfunction
endpackage

// File: rtl/psram_opi_seq_if.sv
// psram_opi_seq_if: request, write/read byte streams, status and PSRAM pin bundle.
interface psram_opi_seq_if;
    import psram_pkg::*;
    logic [PSCR_W-1:0] pscr_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [7:0]        req_cmd_i;
    logic [31:0]       req_addr_i;
    logic              req_wr_i;
    logic [7:0]        req_wait_i;
    logic [7:0]        req_len_i;
    logic [7:0]        wr_data_i;
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [7:0]        rd_data_o;
    logic              rd_valid_o;
    logic              done_o;
    logic              err_o;
    logic              psram_sck_o;
    logic              psram_ce_o;
    logic [7:0]        psram_io_en_o;
    logic [7:0]        psram_io_out_o;
    logic [7:0]        psram_io_in_i;
    logic              psram_dqs_en_o;
    logic              psram_dqs_out_o;
    logic              psram_dqs_in_i;
    modport slave (
        input  pscr_i, req_valid_i, req_cmd_i, req_addr_i, req_wr_i, req_wait_i, req_len_i,
               wr_data_i, wr_valid_i, psram_io_in_i, psram_dqs_in_i,
        output req_ready_o, wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o,
               psram_sck_o, psram_ce_o, psram_io_en_o, psram_io_out_o, psram_dqs_en_o, psram_dqs_out_o
    );
    modport master (
        output pscr_i, req_valid_i, req_cmd_i, req_addr_i, req_wr_i, req_wait_i, req_len_i,
               wr_data_i, wr_valid_i, psram_io_in_i, psram_dqs_in_i,
        input  req_ready_o, wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o,
               psram_sck_o, psram_ce_o, psram_io_en_o, psram_io_out_o, psram_dqs_en_o, psram_dqs_out_o
    );
endinterface

// File: rtl/psram_slot_gen.sv
// psram_slot_gen: counts clk cycles within a P-cycle byte slot and flags start, SCK toggle and last cycle.
module psram_slot_gen
    import psram_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PSCR_W-1:0] p_i,
    input  logic              run_i,
    output logic              slot_start_o,
    output logic              sck_toggle_o,
    output logic              slot_last_o
);
    logic [PSCR_W-1:0] cnt_q, cnt_d;
    assign slot_start_o = run_i && cnt_q == '0;
    assign sck_toggle_o = run_i && cnt_q == (p_i >> 1);
    assign slot_last_o  = run_i && cnt_q == p_i - PSCR_W'(1);
    always_comb cnt_d = (!run_i || slot_last_o) ? '0 : cnt_q + PSCR_W'(1);
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/psram_opi_seq.sv
// psram_opi_seq: slot-timed OPI DDR PSRAM command/address/latency/data sequencer.
module psram_opi_seq
    import psram_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    psram_opi_seq_if.slave bus
);
    state_e            state_q, state_d, nxt;
    logic [PSCR_W-1:0] p_q, p_d;
    logic [7:0]        cmd_q, cmd_d, wait_q, wait_d, len_q, len_d;
    logic [31:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [SLOT_W-1:0] slot_q, slot_d, phase_last;
    logic              ce_q, ce_d, sck_q, sck_d, dqs_en_q, dqs_en_d;
    logic [7:0]        io_en_q, io_en_d, io_out_q, io_out_d, rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d, err_q, err_d;
    logic              slot_start, sck_toggle, slot_last, accept, wr_dat, phase_end;
    psram_slot_gen u_slot (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p_i          (p_q),
        .run_i        (state_q != ST_IDLE),
        .slot_start_o (slot_start),
        .sck_toggle_o (sck_toggle),
        .slot_last_o  (slot_last)
    );
    assign bus.req_ready_o     = state_q == ST_IDLE && !rst_i;
    assign accept              = bus.req_ready_o && bus.req_valid_i;
    assign wr_dat              = state_q == ST_DATA && wr_q;
    assign bus.wr_ready_o      = wr_dat && slot_start;
    assign bus.done_o          = state_q == ST_HOLD && slot_last;
    assign bus.psram_ce_o      = ce_q;
    assign bus.psram_sck_o     = sck_q;
    assign bus.psram_io_en_o   = io_en_q;
    assign bus.psram_io_out_o  = io_out_q;
    assign bus.psram_dqs_en_o  = dqs_en_q;
    assign bus.psram_dqs_out_o = 1'b0;
    assign bus.rd_data_o       = rd_data_q;
    assign bus.rd_valid_o      = rd_valid_q;
    assign bus.err_o           = err_q;
    assign phase_last = state_q == ST_CMD  ? SLOT_W'(CMD_SLOTS - 1) :
                        state_q == ST_ADDR ? SLOT_W'(ADDR_SLOTS - 1) :
                        state_q == ST_WAIT ? SLOT_W'({wait_q, 1'b0} - 9'd1) :
                        state_q == ST_DATA ? {1'b0, len_q, 1'b1} : '0;
    assign phase_end = slot_last && slot_q == phase_last;
    assign nxt = state_q == ST_CMD  ? ST_ADDR :
                 state_q == ST_ADDR ? (wait_q == 8'd0 ? ST_DATA : ST_WAIT) :
                 state_q == ST_WAIT ? ST_DATA :
                 state_q == ST_DATA ? ST_HOLD : ST_IDLE;
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wait_d     = wait_q;
        len_d      = len_q;
        slot_d     = slot_q;
        ce_d       = ce_q;
        sck_d      = sck_q;
        io_en_d    = io_en_q;
        io_out_d   = io_out_q;
        dqs_en_d   = dqs_en_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        if (accept) begin
            state_d = ST_CMD;
            p_d     = eff_p(bus.pscr_i);
            cmd_d   = bus.req_cmd_i;
            addr_d  = bus.req_addr_i & ~32'h1;
            wr_d    = bus.req_wr_i;
            wait_d  = bus.req_wait_i;
            len_d   = bus.req_len_i;
            slot_d  = '0;
            ce_d    = 1'b0;
            err_d   = 1'b0;
        end
        // Pins for the current slot are loaded at its first cycle; a missing write byte drives zero.
        if (slot_start && state_q inside {ST_CMD, ST_ADDR, ST_WAIT, ST_DATA}) begin
            io_en_d  = (state_q == ST_WAIT || (state_q == ST_DATA && !wr_q)) ? 8'h00 : 8'hFF;
            dqs_en_d = wr_dat;
            io_out_d = state_q == ST_CMD  ? cmd_q :
                       state_q == ST_ADDR ? addr_byte(addr_q, slot_q[1:0]) :
                       (wr_dat && bus.wr_valid_i) ? bus.wr_data_i : 8'h00;
            err_d    = err_q | (wr_dat && !bus.wr_valid_i);
        end
        if (sck_toggle && state_q != ST_HOLD) sck_d = ~sck_q;
        if (slot_last && state_q == ST_DATA && !wr_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.psram_io_in_i;
        end
        if (slot_last) slot_d = slot_q + SLOT_W'(1);
        if (phase_end) begin
            slot_d  = '0;
            state_d = nxt;
            if (nxt == ST_HOLD) begin
                ce_d     = 1'b1;
                sck_d    = 1'b0;
                io_en_d  = 8'h00;
                io_out_d = 8'h00;
                dqs_en_d = 1'b0;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            p_q        <= P_MIN;
            cmd_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wait_q     <= '0;
            len_q      <= '0;
            slot_q     <= '0;
            ce_q       <= 1'b1;
            sck_q      <= 1'b0;
            io_en_q    <= '0;
            io_out_q   <= '0;
            dqs_en_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wait_q     <= wait_d;
            len_q      <= len_d;
            slot_q     <= slot_d;
            ce_q       <= ce_d;
            sck_q      <= sck_d;
            io_en_q    <= io_en_d;
            io_out_q   <= io_out_d;
            dqs_en_q   <= dqs_en_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_psram_opi_seq.sv
// tb_psram_opi_seq: cycle-exact slot-timing model of the sequencer, driven with random requests and device bytes.
module tb_psram_opi_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] wpat[$];
    psram_opi_seq_if bus();
    psram_opi_seq dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Slot j covers cycles j*P..j*P+P-1 after the accepting edge; registered pins show slot j one cycle later.
    task automatic run_txn(input int pscr, input bit wr, input logic [7:0] cmd, input logic [31:0] addr,
                           input int w, input int len, input int vmode);
        int p, h, n, d0, ce_low, rd_cnt;
        logic err_m;
        logic [31:0] a;
        logic [7:0] hist [0:1023];
        logic [7:0] wexp [0:511];
        p = pscr < 2 ? 2 : pscr;
        h = p / 2;
        n = 6 + 2 * w + 2 * (len + 1);
        d0 = 6 + 2 * w;
        a = addr & ~32'h1;
        err_m = 1'b0;
        ce_low = 0;
        rd_cnt = 0;
        @(negedge clk);
        bus.pscr_i = 20'(pscr);
        bus.req_cmd_i = cmd;
        bus.req_addr_i = addr;
        bus.req_wr_i = wr;
        bus.req_wait_i = 8'(w);
        bus.req_len_i = 8'(len);
        bus.req_valid_i = 1'b1;
        chk("req_ready_idle", bus.req_ready_o, 1);
        @(posedge clk);
        for (int t = 0; t <= n * p + p; t++) begin
            int j, k, sck_e;
            bit wrr, rv;
            logic v;
            logic [7:0] b;
            @(negedge clk);
            j = (t - 1) / p;
            sck_e = (t >= n * p || t < h + 1) ? 0 : (((t - h - 1) / p) + 1) % 2;
            chk("ce", bus.psram_ce_o, t < n * p ? 0 : 1);
            if (!bus.psram_ce_o) ce_low++;
            chk("sck", bus.psram_sck_o, sck_e);
            if (t >= 1 && t < n * p) begin
                chk("io_en", bus.psram_io_en_o, (j < 6 || (wr && j >= d0)) ? 8'hFF : 8'h00);
                chk("dqs_en", bus.psram_dqs_en_o, wr && j >= d0);
                if (j < 2) chk("io_cmd", bus.psram_io_out_o, cmd);
                else if (j < 6) chk("io_addr", bus.psram_io_out_o, (a >> (8 * (5 - j))) & 32'hFF);
                else if (wr && j >= d0) chk("io_wdata", bus.psram_io_out_o, wexp[j - d0]);
            end else begin
                chk("io_en_off", bus.psram_io_en_o, 0);
                chk("dqs_en_off", bus.psram_dqs_en_o, 0);
            end
            chk("dqs_out", bus.psram_dqs_out_o, 0);
            chk("err", bus.err_o, err_m);
            chk("done", bus.done_o, t == n * p + p - 1);
            chk("req_ready", bus.req_ready_o, t == n * p + p);
            rv = !wr && t % p == 0 && t / p >= d0 + 1 && t <= n * p;
            chk("rd_valid", bus.rd_valid_o, rv);
            if (rv) begin
                chk("rd_data", bus.rd_data_o, hist[t - 1]);
                rd_cnt++;
            end
            wrr = wr && t < n * p && t % p == 0 && t / p >= d0;
            chk("wr_ready", bus.wr_ready_o, wrr);
            if (t == 0) bus.pscr_i = 20'($urandom);
            bus.req_valid_i = t < n * p;
            bus.req_cmd_i = 8'($urandom);
            bus.psram_io_in_i = 8'($urandom);
            hist[t] = bus.psram_io_in_i;
            if (wrr) begin
                k = t / p - d0;
                v = vmode == 0 ? 1'b1 : vmode == 2 ? (k != 1) : ($urandom_range(0, 3) != 0);
                b = k < wpat.size() ? wpat[k] : 8'($urandom);
                bus.wr_valid_i = v;
                bus.wr_data_i = b;
                wexp[k] = v ? b : 8'h00;
                if (!v) err_m = 1'b1;
            end else begin
                bus.wr_valid_i = 1'($urandom);
                bus.wr_data_i = 8'($urandom);
            end
        end
        chk("ce_low_cycles", ce_low, n * p);
        chk("rd_pulses", rd_cnt, wr ? 0 : 2 * (len + 1));
    endtask
    initial begin
        bus.pscr_i = '0;
        bus.req_valid_i = 1'b0;
        bus.req_cmd_i = '0;
        bus.req_addr_i = '0;
        bus.req_wr_i = 1'b0;
        bus.req_wait_i = '0;
        bus.req_len_i = '0;
        bus.wr_data_i = '0;
        bus.wr_valid_i = 1'b0;
        bus.psram_io_in_i = '0;
        bus.psram_dqs_in_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ce", bus.psram_ce_o, 1);
        chk("rst_sck", bus.psram_sck_o, 0);
        chk("rst_io_en", bus.psram_io_en_o, 0);
        chk("rst_io_out", bus.psram_io_out_o, 0);
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_rd_valid", bus.rd_valid_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_err", bus.err_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.req_ready_o, 1);
        run_txn(4, 1'b0, 8'h20, 32'h0000_1235, 3, 1, 0);
        wpat = '{8'h5A, 8'hA5};
        run_txn(2, 1'b1, 8'hA0, 32'h0040_0000, 0, 0, 0);
        run_txn(2, 1'b1, 8'hA0, 32'h0040_0000, 0, 0, 2);
        @(negedge clk);
        chk("err_sticky", bus.err_o, 1);
        wpat.delete();
        run_txn(0, 1'b0, 8'hEE, 32'h1234_5678, 1, 2, 0);
        run_txn(1, 1'b0, 8'hEE, 32'h1234_5678, 1, 2, 0);
        run_txn(2, 1'b0, 8'hEE, 32'h1234_5678, 1, 2, 0);
        run_txn(5, 1'b1, 8'hC0, 32'h0000_0004, 0, 0, 0);
        @(negedge clk);
        bus.pscr_i = 20'd3;
        bus.req_wr_i = 1'b0;
        bus.req_wait_i = 8'd2;
        bus.req_len_i = 8'd1;
        bus.req_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ce", bus.psram_ce_o, 1);
        chk("mid_rst_sck", bus.psram_sck_o, 0);
        chk("mid_rst_io_en", bus.psram_io_en_o, 0);
        chk("mid_rst_ready", bus.req_ready_o, 0);
        chk("mid_rst_done", bus.done_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_rel", bus.req_ready_o, 1);
        for (int i = 0; i < 24; i++) begin
            bit wr;
            wr = 1'($urandom);
            run_txn($urandom_range(0, 6), wr, 8'($urandom), $urandom, $urandom_range(0, 4),
                    $urandom_range(0, 7), wr ? 1 : 0);
            bus.req_valid_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/psram_opi_seq.md
PSRAM_OPI_SEQ -- requirements
Module: psram_opi_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed clock and reset first.
REQ-002 clk_i  in  1  core clock; every register is clocked on its rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 pscr_i  in  20  slot length in clk_i cycles per byte slot; values below 2 are treated as 2.
REQ-005 req_valid_i / req_ready_o  in/out  1/1  transaction request handshake.
REQ-006 req_cmd_i  in  8  OPI command byte.
REQ-007 req_addr_i  in  32  byte address; bit 0 is forced to 0 on the pins.
REQ-008 req_wr_i  in  1  1 = write, 0 = read.
REQ-009 req_wait_i  in  8  latency in SCK cycles; 0 means no latency phase.
REQ-010 req_len_i  in  8  number of 2-byte beats minus 1, giving 2..512 bytes.
REQ-011 wr_data_i / wr_valid_i / wr_ready_o  in/in/out  8/1/1  write byte stream.
REQ-012 rd_data_o / rd_valid_o  out/out  8/1  read byte stream; there is no backpressure.
REQ-013 done_o  out  1  one-cycle pulse when the transaction ends.
REQ-014 err_o  out  1  sticky write-underrun flag; it clears when the next request is accepted.
REQ-015 psram_sck_o, psram_ce_o, psram_io_en_o[7:0], psram_io_out_o[7:0], psram_io_in_i[7:0], psram_dqs_en_o, psram_dqs_out_o, psram_dqs_in_i  PSRAM pin bundle (dut side).

Function
REQ-016 The FSM SHALL have the states IDLE, CMD, ADDR, WAIT, DATA and HOLD.
REQ-017 req_ready_o SHALL be 1 only in IDLE; acceptance latches all req_* fields and pscr_i, sets psram_ce_o=0, and enters CMD.
REQ-018 Timing SHALL be slot-based, with one slot = P clk_i cycles, where P is the latched pscr value with a minimum of 2.
REQ-019 psram_io_out_o SHALL update on slot cycle 0, and psram_sck_o SHALL toggle on slot cycle floor(P/2), giving one byte per SCK edge (DDR).
REQ-020 Slot counts per phase SHALL be: CMD 2 slots (cmd, cmd); ADDR 4 slots (addr[31:24] first, addr[7:0] last with bit0=0); WAIT 2*wait slots; DATA 2*(len+1) slots.
REQ-021 psram_io_en_o SHALL be 8'hFF in CMD and ADDR, in DATA when writing, and 8'h00 otherwise.
REQ-022 During write DATA, psram_dqs_en_o SHALL be 1 and psram_dqs_out_o SHALL be 0 (no mask); otherwise psram_dqs_en_o SHALL be 0.
REQ-023 On write, wr_ready_o SHALL pulse on slot cycle 0 of each DATA slot, and the byte SHALL be taken if wr_valid_i=1.
REQ-024 If wr_valid_i=0 at that pulse, the block SHALL drive 8'h00 for that slot and set err_o; the transaction continues.
REQ-025 On read, psram_io_in_i SHALL be captured on the last cycle (P-1) of each DATA slot, with rd_valid_o pulsing on the following cycle.
REQ-026 After the last DATA slot, the FSM SHALL enter HOLD: psram_ce_o=1, psram_sck_o=0, psram_io_en_o=0 for one slot.
REQ-027 done_o SHALL pulse on the final HOLD cycle, and the FSM SHALL return to IDLE on the next cycle.
REQ-028 Every transaction SHALL have an even number of SCK edges, so psram_sck_o is 0 on entry to HOLD.
REQ-029 With req_wait_i=0, the FSM SHALL go ADDR->DATA directly.
REQ-030 req_valid_i SHALL be ignored outside IDLE, and pscr_i changes SHALL be ignored mid-transaction.

Reset
REQ-031 On rst_i=1 at any time, including mid-transaction, the following SHALL take effect on the next edge: state=IDLE, psram_ce_o=1, psram_sck_o=0, psram_io_en_o=0, psram_io_out_o=0, psram_dqs_en_o=0, psram_dqs_out_o=0, req_ready_o=0 during reset, wr_ready_o=0, rd_valid_o=0, rd_data_o=0, done_o=0, err_o=0, and all counters=0.

Structure
REQ-032 The shared package psram_pkg SHALL hold the FSM state enum, the slot counts (CMD 2, ADDR 4), and the minimum slot length of 2 tied to the PSCR width of 20.
REQ-033 Slot counting and SCK generation SHALL reside in one sub-module, psram_slot_gen (inputs P, run; outputs slot_start, sck_toggle, slot_last).

Verification
REQ-034 With P=4, read cmd 8'h20, addr 32'h0000_1235, wait 3, len 1: the bench SHALL see CE low for 16 slots = 64 cycles, pins 20,20,00,00,12,34, 6 wait slots, 4 rd_valid_o pulses with the device-model bytes, then done_o.
REQ-035 With P=2, write cmd 8'hA0, len 0, wr_valid_i always 1 with bytes 8'h5A, 8'hA5: the bench SHALL see psram_io_out_o carry 5A then A5 with io_en=FF, dqs_en=1, and err_o=0.
REQ-036 In the same write with wr_valid_i low on the second byte: the bench SHALL see 8'h00 driven in that slot, err_o=1 after it, and err_o clearing on the next acceptance.
REQ-037 With pscr_i=0 and pscr_i=1: the bench SHALL see behaviour identical to pscr_i=2, with an SCK period of 4 clk_i cycles.
REQ-038 Asserting rst_i during ADDR: the bench SHALL see the next cycle show ce=1, sck=0, io_en=0, and req_ready_o=1 once rst_i drops.
REQ-039 Register write cmd 8'hC0, wait 0, len 0: the bench SHALL see no WAIT phase, with total CE-low time equal to 8 slots.
